if_id_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline. It sits directly upstream of the ID/EX register. It owns the PC, drives the instruction-memory address and captures the fetched word with its PC+4. It also detects load-use hazards against the instruction held in ID/EX, and squashes the fetched instruction on a taken branch or jump resolved in ID. Two saturating event counters are included for performance bring-up.

---
 rtl/if_id_stage.sv | 121 ++++++++++++
 tb/tb_if_id_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for a 5-stage MIPS pipeline.
// Owns the PC, captures fetched words with their PC+4, and detects load-use
// hazards against ID/EX. Taken branches resolved in ID squash the fetched word.
// Two saturating counters (hazard stall cycles, branch flushes) aid bring-up.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_ready_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rt_i,
    input  logic        ext_stall_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic        hazard_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    // Saturating increment: sticks at all-ones instead of wrapping to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        logic [15:0] res;
        if (cnt == 16'hFFFF) begin
            res = cnt;
        end else begin
            res = cnt + 16'd1;
        end
        return res;
    endfunction

    // True when the ID/EX load destination matches a source field of the ID instruction.
    function automatic logic load_use(input logic        memread,
                                      input logic        valid,
                                      input logic [4:0]  rt,
                                      input logic [31:0] inst);
        return memread & valid & (rt != 5'd0) &
               ((rt == inst[25:21]) | (rt == inst[20:16]));
    endfunction

    logic [31:0] pc_q,        pc_d;
    logic [31:0] inst_q,      inst_d;
    logic [31:0] pc_plus4_q,  pc_plus4_d;
    logic        valid_q,     valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] pc_inc_s;
    logic        hazard_s;

    // Sequential PC increment wraps modulo 2^32 by construction of the 32-bit add.
    assign pc_inc_s = pc_q + 32'd4;
    assign hazard_s = load_use(idex_memread_i, valid_q, idex_rt_i, inst_q);

    // Next-state selection: first matching rule wins (stall, hazard, branch, wait, fetch).
    always_comb begin
        pc_d        = pc_q;
        inst_d      = inst_q;
        pc_plus4_d  = pc_plus4_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (ext_stall_i) begin
            // Whole front end frozen; a held branch in ID will reassert later.
            pc_d = pc_q;
        end else if (hazard_s) begin
            // Branch is ignored: its operand may be the load result not yet available.
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else if (branch_i) begin
            // Fetched word is on the wrong path; drop it and redirect.
            pc_d        = branch_target_i;
            inst_d      = NOP;
            valid_d     = 1'b0;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (!imem_ready_i) begin
            // Memory not ready: bubble into ID, retry same PC next cycle.
            inst_d  = NOP;
            valid_d = 1'b0;
        end else begin
            inst_d     = imem_rdata_i;
            pc_plus4_d = pc_inc_s;
            valid_d    = 1'b1;
            pc_d       = pc_inc_s;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inst_q      <= NOP;
            pc_plus4_q  <= 32'h0000_0000;
            valid_q     <= 1'b0;
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;
    assign inst_o      = inst_q;
    assign pc_plus4_o  = pc_plus4_q;
    assign valid_o     = valid_q;
    assign hazard_o    = hazard_s;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage. Inputs change on the falling
// edge; outputs are sampled on the falling edge or shortly after an input change.
module tb_if_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic        imem_ready_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        idex_memread_i;
    logic [4:0]  idex_rt_i;
    logic        ext_stall_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        hazard_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    int n_cmp;
    int n_mis;

    if_id_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP     (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr_o    (imem_addr_o),
        .imem_rdata_i   (imem_rdata_i),
        .imem_ready_i   (imem_ready_i),
        .branch_i       (branch_i),
        .branch_target_i(branch_target_i),
        .idex_memread_i (idex_memread_i),
        .idex_rt_i      (idex_rt_i),
        .ext_stall_i    (ext_stall_i),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .pc_plus4_o     (pc_plus4_o),
        .valid_o        (valid_o),
        .hazard_o       (hazard_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_mis = n_mis + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                               input logic [31:0] pp4, input logic vld);
        check_eq({tag, ".pc"},    pc_o,        pc);
        check_eq({tag, ".addr"},  imem_addr_o, pc);
        check_eq({tag, ".inst"},  inst_o,      inst);
        check_eq({tag, ".pp4"},   pc_plus4_o,  pp4);
        check_eq({tag, ".valid"}, {31'd0, valid_o}, {31'd0, vld});
    endtask

    task automatic check_cnt(input string tag, input logic [15:0] st, input logic [15:0] fl);
        check_eq({tag, ".stall_cnt"}, {16'd0, stall_cnt_o}, {16'd0, st});
        check_eq({tag, ".flush_cnt"}, {16'd0, flush_cnt_o}, {16'd0, fl});
    endtask

    initial begin
        n_cmp           = 0;
        n_mis           = 0;
        rst_n           = 1'b0;
        imem_ready_i    = 1'b1;
        imem_rdata_i    = 32'h8C01_0004;
        branch_i        = 1'b0;
        branch_target_i = 32'h0000_0000;
        idex_memread_i  = 1'b0;
        idex_rt_i       = 5'd0;
        ext_stall_i     = 1'b0;

        // Reset values, then release and confirm nothing moves before the edge.
        @(negedge clk);
        check_state("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        check_cnt("rst", 16'd0, 16'd0);
        check_eq("rst.hazard", {31'd0, hazard_o}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_state("prerel", 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check_state("first", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);

        // Load-use: rs=1, rt=2 in IF/ID.
        imem_rdata_i = 32'h0022_1820;
        tick();
        check_state("fetch2", 32'h8, 32'h0022_1820, 32'h8, 1'b1);
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd1;
        imem_rdata_i   = 32'hDEAD_BEEF;
        #1;
        check_eq("lu.hazard", {31'd0, hazard_o}, 32'd1);
        tick();
        check_state("lu.hold", 32'h8, 32'h0022_1820, 32'h8, 1'b1);
        check_cnt("lu", 16'd1, 16'd0);
        idex_rt_i = 5'd0;
        #1;
        check_eq("lu.rt0", {31'd0, hazard_o}, 32'd0);
        idex_rt_i = 5'd2;
        #1;
        check_eq("lu.rt2", {31'd0, hazard_o}, 32'd1);
        idex_memread_i = 1'b0;
        #1;
        check_eq("lu.nomem", {31'd0, hazard_o}, 32'd0);

        // Walk to pc=0x10, then branch to 0x40.
        imem_rdata_i = 32'h1111_1111;
        tick();
        imem_rdata_i = 32'h2222_2222;
        tick();
        check_state("pre_br", 32'h10, 32'h2222_2222, 32'h10, 1'b1);
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_0040;
        imem_rdata_i    = 32'h3333_3333;
        tick();
        check_state("br", 32'h40, 32'h0, 32'h10, 1'b0);
        check_cnt("br", 16'd1, 16'd0 + 16'd1 - 16'd1 + 16'd1 - 16'd1 + 16'd1);
        branch_i     = 1'b0;
        imem_rdata_i = 32'h4444_4444;
        tick();
        check_state("br_tgt", 32'h44, 32'h4444_4444, 32'h44, 1'b1);

        // Priority: ext stall + hazard (rs=2) + branch all at once.
        ext_stall_i     = 1'b1;
        idex_memread_i  = 1'b1;
        idex_rt_i       = 5'd2;
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_0080;
        #1;
        check_eq("pri.hazard", {31'd0, hazard_o}, 32'd1);
        tick();
        check_state("pri.ext", 32'h44, 32'h4444_4444, 32'h44, 1'b1);
        check_cnt("pri.ext", 16'd1, 16'd1);
        ext_stall_i = 1'b0;
        tick();
        check_state("pri.haz", 32'h44, 32'h4444_4444, 32'h44, 1'b1);
        check_cnt("pri.haz", 16'd2, 16'd1);
        idex_memread_i = 1'b0;

        // Redirect to the top of the address space, then memory wait and wrap.
        branch_target_i = 32'hFFFF_FFFC;
        tick();
        check_state("br2", 32'hFFFF_FFFC, 32'h0, 32'h44, 1'b0);
        check_cnt("br2", 16'd2, 16'd2);
        branch_i     = 1'b0;
        imem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("wait", 32'hFFFF_FFFC, 32'h0, 32'h44, 1'b0);
        end
        imem_ready_i = 1'b1;
        imem_rdata_i = 32'h5555_5555;
        tick();
        check_state("wrap", 32'h0, 32'h5555_5555, 32'h0, 1'b1);

        // Hazard (rs=10) with memory not ready: the real instruction is held.
        imem_ready_i   = 1'b0;
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd10;
        tick();
        check_state("haz_wait", 32'h0, 32'h5555_5555, 32'h0, 1'b1);
        check_cnt("haz_wait", 16'd3, 16'd2);

        // Saturation of the stall counter.
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        @(negedge clk);
        check_cnt("sat", 16'hFFFF, 16'd2);
        check_state("sat", 32'h0, 32'h5555_5555, 32'h0, 1'b1);

        // Asynchronous reset pulse between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_state("arst", 32'h0, 32'h0, 32'h0, 1'b0);
        check_cnt("arst", 16'd0, 16'd0);
        check_eq("arst.hazard", {31'd0, hazard_o}, 32'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        idex_memread_i = 1'b0;
        imem_ready_i   = 1'b1;
        imem_rdata_i   = 32'h8C01_0004;
        tick();
        check_state("post_rst", 32'h4, 32'h8C01_0004, 32'h4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
